// File: rtl/prog_loader.sv
// Program-image loader for the gpu core: packs a valid/ready stream of shader
// words into a DATA_DEPTH-entry image, zero-fills the tail, then reports done.
module prog_loader #(
  parameter int DATA_DEPTH = 1024,
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         word_valid,
  input  logic [WORD_W-1:0]            word_data,
  input  logic                         word_last,
  output logic                         word_ready,
  output logic                         prog_loading,
  output logic [DATA_DEPTH*WORD_W-1:0] data_frames_in,
  output logic [ADDR_W:0]              words_loaded,
  output logic                         load_done,
  output logic                         truncated
);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DATA_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] clr_ptr;
  logic [WORD_W-1:0] image [DATA_DEPTH];

  logic accept;
  logic at_last_entry;
  logic start_ok;

  assign accept        = word_valid && word_ready;
  assign at_last_entry = (wr_ptr == LAST_IDX);
  assign start_ok      = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = LOAD;
      LOAD: begin
        if (accept) begin
          if (at_last_entry) begin
            next_state = DONE;
          end else if (word_last) begin
            next_state = CLEAR;
          end
        end
      end
      CLEAR: if (clr_ptr == LAST_IDX) next_state = DONE;
      DONE:  if (start) next_state = LOAD;
    endcase
  end

  always_comb begin
    word_ready = (state == LOAD);
  end

  // Status outputs are registered from the next-state decode so they change
  // on the same edge as the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      clr_ptr      <= '0;
      words_loaded <= '0;
      truncated    <= 1'b0;
      prog_loading <= 1'b1;
      load_done    <= 1'b0;
    end else begin
      prog_loading <= (next_state != DONE);
      load_done    <= (next_state == DONE) && (state != DONE);
      if (start_ok) begin
        wr_ptr       <= '0;
        words_loaded <= '0;
        truncated    <= 1'b0;
      end else if (accept) begin
        words_loaded <= words_loaded + CNT_ONE;
        if (at_last_entry) begin
          truncated <= !word_last;
        end else begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (word_last) begin
            clr_ptr <= wr_ptr + PTR_ONE;
          end
        end
      end else if (state == CLEAR) begin
        clr_ptr <= clr_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DATA_DEPTH; j++) begin
        image[j] <= '0;
      end
    end else if (accept) begin
      image[wr_ptr] <= word_data;
    end else if (state == CLEAR) begin
      image[clr_ptr] <= '0;
    end
  end

  for (genvar j = 0; j < DATA_DEPTH; j++) begin : g_flatten
    assign data_frames_in[WORD_W*j +: WORD_W] = image[j];
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized word streams checked every cycle against
// an event-level model of the program image and status outputs.
module tb_prog_loader;

  localparam int DEPTH = 1024;
  localparam int W     = 16;
  localparam int AW    = 10;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               word_valid = 1'b0;
  logic [W-1:0]       word_data = '0;
  logic               word_last = 1'b0;
  logic               word_ready;
  logic               prog_loading;
  logic [DEPTH*W-1:0] data_frames_in;
  logic [AW:0]        words_loaded;
  logic               load_done;
  logic               truncated;

  int n_checks = 0;
  int n_fail   = 0;

  prog_loader #(.DATA_DEPTH(DEPTH), .WORD_W(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
    .prog_loading(prog_loading), .data_frames_in(data_frames_in),
    .words_loaded(words_loaded), .load_done(load_done), .truncated(truncated)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int entry(input int j);
    return int'(data_frames_in[W*j +: W]);
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic         s_rst = 1'b0, s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [W-1:0] s_data = '0;
  initial forever begin
    @(posedge clk);
    s_rst = reset; s_start = start; s_valid = word_valid;
    s_last = word_last; s_data = word_data;
  end

  // Model: image array plus the edge numbers of the final accept and of completion.
  logic [W-1:0] m_img [DEPTH];
  int           m_e, m_n, m_tlast, m_done;
  bit           m_loading, m_trunc;

  initial begin : compare
    bit in_load, in_clear, can_start;
    int bad;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_e = 0; m_n = 0; m_tlast = 0; m_done = -1; m_loading = 0; m_trunc = 0;
        for (int j = 0; j < DEPTH; j++) m_img[j] = '0;
      end else if (s_rst) begin
        in_load   = m_loading;
        in_clear  = !m_loading && (m_done >= 0) && (m_e < m_done);
        can_start = !in_load && !in_clear;
        m_e++;
        if (in_load && s_valid) begin
          m_img[m_n] = s_data;
          m_n++;
          if (m_n == DEPTH) begin
            m_loading = 0; m_tlast = m_e; m_done = m_e; m_trunc = !s_last;
          end else if (s_last) begin
            m_loading = 0; m_tlast = m_e; m_done = m_e + DEPTH - m_n;
          end
        end else if (in_clear) begin
          m_img[m_n + (m_e - m_tlast) - 1] = '0;
        end
        if (can_start && s_start) begin
          m_loading = 1; m_n = 0; m_trunc = 0; m_done = -1;
        end
      end
      check("word_ready", word_ready, m_loading);
      check("prog_loading", prog_loading, !((m_done >= 0) && (m_e >= m_done)));
      check("load_done", load_done, (m_done >= 0) && (m_e == m_done));
      check("words_loaded", words_loaded, m_n);
      check("truncated", truncated, m_trunc);
      bad = -1;
      for (int j = 0; j < DEPTH; j++) begin
        if (bad < 0 && entry(j) != int'(m_img[j])) bad = j;
      end
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL image entry %0d: got 0x%0h, expected 0x%0h (t=%0t)",
                 bad, entry(bad), m_img[bad], $time);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last, input bit gaps);
    bit rdy;
    int guard;
    if (gaps) repeat ($urandom_range(0, 3)) step();
    word_valid = 1'b1; word_data = d; word_last = last;
    rdy = 1'b0; guard = 0;
    while (!rdy && guard < 50) begin
      rdy = word_ready;
      step();
      guard++;
    end
    check("send_accepted", rdy, 1);
    word_valid = 1'b0; word_last = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (prog_loading && k < 3000) begin
      step();
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int k;
    logic [W-1:0] w [16];
    logic [W-1:0] d;

    // Reset state
    repeat (5) step();
    check("rst_image_zero", int'(|data_frames_in), 0);
    check("rst_prog_loading", prog_loading, 1);
    check("rst_word_ready", word_ready, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_load_done", load_done, 0);
    reset = 1'b1;
    step();
    check("idle_prog_loading", prog_loading, 1);

    // 224-word program, back to back
    pulse_start();
    for (int i = 0; i < 224; i++) send(W'(16'h1000 + i), i == 223, 0);
    wait_done(k);
    check("t2_latency", k, 800);
    check("t2_load_done_set", load_done, 1);
    check("t2_entry0", entry(0), 16'h1000);
    check("t2_entry223", entry(223), 16'h10DF);
    check("t2_entry224", entry(224), 0);
    check("t2_words_loaded", words_loaded, 224);
    check("t2_truncated", truncated, 0);
    step();
    check("t2_load_done_clear", load_done, 0);

    // Short reload over the previous image
    pulse_start();
    check("t5_loading_after_start", prog_loading, 1);
    for (int i = 0; i < 4; i++) send(16'hAAAA, i == 3, 0);
    wait_done(k);
    check("t5_latency", k, 1020);
    check("t5_entry0", entry(0), 16'hAAAA);
    check("t5_entry3", entry(3), 16'hAAAA);
    check("t5_entry4", entry(4), 0);
    check("t5_entry223", entry(223), 0);

    // 16 random words with random valid gaps
    step();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      w[i] = W'($urandom);
      send(w[i], i == 15, 1);
    end
    wait_done(k);
    check("t3_latency", k, 1008);
    for (int i = 0; i < 16; i++) check("t3_entry", entry(i), int'(w[i]));
    check("t3_entry16", entry(16), 0);
    check("t3_words_loaded", words_loaded, 16);

    // Full image without word_last
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      d = W'(i) ^ 16'h5A5A;
      send(d, 1'b0, 0);
    end
    check("t4_prog_loading_fell", prog_loading, 0);
    check("t4_load_done", load_done, 1);
    check("t4_truncated", truncated, 1);
    check("t4_words_loaded", words_loaded, 1024);
    check("t4_entry0", entry(0), 16'h5A5A);
    check("t4_entry1023", entry(1023), 16'h59A5);
    word_valid = 1'b1; word_data = 16'hDEAD;
    repeat (10) begin
      check("t4_no_ready", word_ready, 0);
      step();
    end
    word_valid = 1'b0;
    check("t4_entry1023_hold", entry(1023), 16'h59A5);

    // start during LOAD is ignored, then reset in the middle of CLEAR
    pulse_start();
    for (int i = 0; i < 3; i++) send(W'(16'h3000 + i), 1'b0, 0);
    pulse_start();
    for (int i = 3; i < 5; i++) send(W'(16'h3000 + i), i == 4, 0);
    check("t6_entry0", entry(0), 16'h3000);
    check("t6_entry3", entry(3), 16'h3003);
    check("t6_entry4", entry(4), 16'h3004);
    check("t6_words_loaded", words_loaded, 5);
    repeat (100) step();
    check("t6_in_clear", prog_loading, 1);
    reset = 1'b0;
    step();
    check("t6_image_zero", int'(|data_frames_in), 0);
    check("t6_prog_loading", prog_loading, 1);
    check("t6_word_ready", word_ready, 0);
    check("t6_words_loaded_rst", words_loaded, 0);
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    check("t6_idle_no_ready", word_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the gpu core.
- Accepts a stream of 16-bit shader instruction words over a valid/ready handshake and builds the flattened DATA_DEPTH-entry program image that drives gpu.data_frames_in.
- Zero-fills every unused entry after the last word.
- Drives gpu.prog_loading high for the whole load/clear sequence and drops it only once the image is complete.

Parameters:
- DATA_DEPTH, 1024, number of program entries.
- WORD_W, 16, instruction width in bits.
- ADDR_W, 10, entry index width; must satisfy 2**ADDR_W >= DATA_DEPTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a new program load; sampled only in IDLE or DONE.
- word_valid  in  1  word_data/word_last are valid.
- word_data  in  WORD_W  instruction word.
- word_last  in  1  marks the final word of the program.
- word_ready  out  1  loader can accept a word this cycle.
- prog_loading  out  1  to gpu; high while the image is incomplete.
- data_frames_in  out  DATA_DEPTH*WORD_W  program image; entry j at bits [WORD_W*j+WORD_W-1 : WORD_W*j].
- words_loaded  out  ADDR_W+1  words accepted in the current/last load.
- load_done  out  1  one-cycle pulse when the image is complete.
- truncated  out  1  sticky; load ended at DATA_DEPTH words without word_last.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - All data_frames_in entries 0.
  - prog_loading=1, word_ready=0, words_loaded=0, load_done=0, truncated=0.
  - Internal wr_ptr and clr_ptr = 0.
  - Reset asserted mid-LOAD or mid-CLEAR aborts immediately to these values.
- All outputs are registered, except word_ready, which is decoded combinationally from state (1 only in LOAD).
- States: IDLE, LOAD, CLEAR, DONE.
- IDLE:
  - prog_loading=1, word_valid ignored.
  - start=1 -> LOAD; wr_ptr=0, words_loaded=0, truncated=0.
- LOAD:
  - Accept occurs when word_valid && word_ready at a rising edge.
  - On accept: entry[wr_ptr] <= word_data, wr_ptr+1, words_loaded+1. The entry is visible the cycle after the edge.
  - No accept: nothing changes; gaps in word_valid are allowed.
  - Accept with word_last=1 and wr_ptr < DATA_DEPTH-1 -> CLEAR, clr_ptr = wr_ptr+1.
  - Accept at wr_ptr = DATA_DEPTH-1 -> DONE on the same edge (nothing to clear). If word_last=0 on that accept, set truncated=1.
  - start is ignored in LOAD.
- CLEAR:
  - Each cycle: entry[clr_ptr] <= 0, clr_ptr+1. word_ready=0.
  - The edge that clears entry DATA_DEPTH-1 also moves to DONE.
  - Duration is exactly DATA_DEPTH-N cycles for an N-word program.
  - start is ignored in CLEAR.
- DONE:
  - prog_loading <= 0 and load_done <= 1 on the entering edge.
  - load_done clears on the next edge.
  - Image, words_loaded and truncated hold.
  - start=1 -> LOAD, with prog_loading <= 1 on that edge and wr_ptr/words_loaded/truncated cleared. Old entries remain until overwritten or cleared by the new load.
- Latency:
  - Last accept at edge T with N < DATA_DEPTH words -> prog_loading falls at edge T+(DATA_DEPTH-N).
  - N = DATA_DEPTH -> prog_loading falls at edge T.
- A word presented with word_valid=1 while word_ready=0 is not consumed; the source must hold it.
- No wrap-around: wr_ptr never exceeds DATA_DEPTH-1. word_ready is 0 after the final accept.

Test Plan:
1. Assert reset=0 for 5 cycles, then release -> all 1024 entries 0x0000, prog_loading=1, word_ready=0, words_loaded=0, load_done=0.
2. Pulse start, then stream 224 words 0x1000+i back-to-back with word_last on i=223 -> entries 0..223 = 0x1000..0x10DF and 224..1023 = 0.
   - prog_loading falls exactly 800 edges after the last accept.
   - load_done is high for 1 cycle; words_loaded=224; truncated=0.
3. Stream 16 words with word_valid toggled pseudo-randomly -> entries 0..15 hold exactly words 0..15, with no duplicates or skips; words_loaded=16.
4. Stream 1024 words with word_last never set -> DONE on the 1024th accept edge; truncated=1; prog_loading falls that edge; word_ready=0 afterwards, and extra valid words are never consumed.
5. After test 2, pulse start and load 4 words 0xAAAA with word_last on the 4th -> entries 0..3 = 0xAAAA and 4..1023 = 0; prog_loading is high from the start edge until the clear completes.
6. Pull reset low 100 cycles into CLEAR -> all entries read 0, state IDLE, prog_loading=1 on the next observation; a start pulse asserted during LOAD has no effect on wr_ptr.
